// File: rtl/hex_display_scanner.sv
// Multiplexed N-digit hex 7-segment scanner; seg_out/digit_en are registered one clock behind the scan index.
// One value can be pending at a time. It is held off (load_ready low) until the next frame boundary swaps it in.
module hex_display_scanner #(
   parameter int DIGITS       = 4,
   parameter int SCAN_DIV     = 1000,
   parameter int BLINK_FRAMES = 64,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic [4*DIGITS-1:0]   load_value,
   input  logic [DIGITS-1:0]     load_blank,
   input  logic                  lz_suppress,
   input  logic                  blink_en,
   output logic [6:0]            seg_out,
   output logic [DIGITS-1:0]     digit_en
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int SC_W  = $clog2(SCAN_DIV);
   localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [SC_W-1:0]     scan_cnt_q, scan_cnt_d;
   logic [FC_W-1:0]     frame_cnt_q, frame_cnt_d;
   logic                blink_phase_q, blink_phase_d;
   logic [4*DIGITS-1:0] shown_val_q, shown_val_d;
   logic [DIGITS-1:0]   shown_blank_q, shown_blank_d;
   logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
   logic [DIGITS-1:0]   pend_blank_q, pend_blank_d;
   logic                pend_vld_q, pend_vld_d;
   logic                ready_q, ready_d;
   logic [6:0]          seg_q, seg_d;
   logic [DIGITS-1:0]   digit_en_q, digit_en_d;

   logic                tick, last_digit, frame_end, accept;
   logic [3:0]          nib;
   logic                blank_bit, upper_nz, dark;
   logic [DIGITS-1:0]   onehot;
   logic [6:0]          seg_lo;

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q         <= '0;
         scan_cnt_q    <= '0;
         frame_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         shown_val_q   <= '0;
         shown_blank_q <= '0;
         pend_val_q    <= '0;
         pend_blank_q  <= '0;
         pend_vld_q    <= 1'b0;
         ready_q       <= 1'b0;
         seg_q         <= {7{ACTIVE_LOW}};
         digit_en_q    <= {DIGITS{ACTIVE_LOW}};
      end else begin
         idx_q         <= idx_d;
         scan_cnt_q    <= scan_cnt_d;
         frame_cnt_q   <= frame_cnt_d;
         blink_phase_q <= blink_phase_d;
         shown_val_q   <= shown_val_d;
         shown_blank_q <= shown_blank_d;
         pend_val_q    <= pend_val_d;
         pend_blank_q  <= pend_blank_d;
         pend_vld_q    <= pend_vld_d;
         ready_q       <= ready_d;
         seg_q         <= seg_d;
         digit_en_q    <= digit_en_d;
      end
   end

   always_comb begin
      tick          = (scan_cnt_q == SC_W'(SCAN_DIV - 1));
      last_digit    = (idx_q == IDX_W'(DIGITS - 1));
      frame_end     = tick && last_digit;
      accept        = load_valid && ready_q;

      scan_cnt_d    = tick ? '0 : scan_cnt_q + SC_W'(1);
      idx_d         = idx_q;
      if (tick) begin
         idx_d = last_digit ? '0 : idx_q + IDX_W'(1);
      end

      frame_cnt_d   = frame_cnt_q;
      blink_phase_d = blink_phase_q;
      if (frame_end) begin
         if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
            frame_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            frame_cnt_d   = frame_cnt_q + FC_W'(1);
         end
      end

      // A value accepted on the boundary cycle itself is not yet pending, so it waits a full frame.
      shown_val_d   = shown_val_q;
      shown_blank_d = shown_blank_q;
      pend_val_d    = pend_val_q;
      pend_blank_d  = pend_blank_q;
      pend_vld_d    = pend_vld_q;
      if (frame_end && pend_vld_q) begin
         shown_val_d   = pend_val_q;
         shown_blank_d = pend_blank_q;
         pend_vld_d    = 1'b0;
      end
      if (accept) begin
         pend_val_d   = load_value;
         pend_blank_d = load_blank;
         pend_vld_d   = 1'b1;
      end
      ready_d = ~pend_vld_d;
   end

   always_comb begin
      nib       = 4'h0;
      blank_bit = 1'b0;
      upper_nz  = 1'b0;
      onehot    = '0;
      for (int j = 0; j < DIGITS; j++) begin
         if (IDX_W'(j) == idx_q) begin
            nib       = shown_val_q[4*j +: 4];
            blank_bit = shown_blank_q[j];
            onehot[j] = 1'b1;
         end
         if ((IDX_W'(j) >= idx_q) && (shown_val_q[4*j +: 4] != 4'h0)) begin
            upper_nz = 1'b1;
         end
      end

      dark = blank_bit
           || (lz_suppress && (idx_q != '0) && !upper_nz)
           || (blink_en && blink_phase_q);

      // Table is in active-low form {g,f,e,d,c,b,a}.
      case (nib)
         4'h0:    seg_lo = 7'b1000000;
         4'h1:    seg_lo = 7'b1111001;
         4'h2:    seg_lo = 7'b0100100;
         4'h3:    seg_lo = 7'b0110000;
         4'h4:    seg_lo = 7'b0011001;
         4'h5:    seg_lo = 7'b0010010;
         4'h6:    seg_lo = 7'b0000010;
         4'h7:    seg_lo = 7'b1111000;
         4'h8:    seg_lo = 7'b0000000;
         4'h9:    seg_lo = 7'b0011000;
         4'hA:    seg_lo = 7'b0001000;
         4'hB:    seg_lo = 7'b0000011;
         4'hC:    seg_lo = 7'b1000110;
         4'hD:    seg_lo = 7'b0100001;
         4'hE:    seg_lo = 7'b0000110;
         default: seg_lo = 7'b0001110;
      endcase

      seg_d      = dark ? 7'h7F : seg_lo;
      digit_en_d = ~onehot;
      if (!ACTIVE_LOW) begin
         seg_d      = ~seg_d;
         digit_en_d = onehot;
      end
   end

   assign load_ready = ready_q;
   assign seg_out    = seg_q;
   assign digit_en   = digit_en_q;

endmodule
